// File: rtl/jt51_sh_ram_if.sv
// Slot-bus bundle for jt51_sh_ram: clock enable, clear, data in, tap select,
// and the delayed outputs with the clear-sweep busy flag.
interface jt51_sh_ram_if #(
  parameter int width  = 5,
  parameter int stages = 32
);
  localparam int dw = $clog2(stages + 1);

  logic             cen;
  logic             clr;
  logic [width-1:0] din;
  logic [dw-1:0]    tap_dly;
  logic [width-1:0] drop;
  logic [width-1:0] tap;
  logic             busy;

  modport master (
    output cen, clr, din, tap_dly,
    input  drop, tap, busy
  );

  modport slave (
    input  cen, clr, din, tap_dly,
    output drop, tap, busy
  );
endinterface

// File: rtl/jt51_sh_ram.sv
// RAM-backed time-multiplexed delay line with clear sweep and busy flag.
// Define JT51_SH_TAP_EN to build the programmable mid-line tap read port.
module jt51_sh_ram #(
  parameter int               width  = 5,
  parameter int               stages = 32,
  parameter logic [width-1:0] rstval = {width{1'b0}}
) (
  input  logic         clk,
  input  logic         rst_n,
  jt51_sh_ram_if.slave bus
);

  localparam int pw  = (stages > 1) ? $clog2(stages) : 1;
  localparam int pw1 = pw + 1;
  localparam logic [pw-1:0] PTR_ZERO = {pw{1'b0}};
  localparam logic [pw-1:0] PTR_ONE  = pw'(1);
  localparam logic [pw-1:0] PTR_LAST = pw'(stages - 1);

  typedef enum logic [0:0] {
    ST_CLR = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic [pw-1:0]    ptr_r;
  logic [pw-1:0]    ptr_nx_s;
  logic             busy_s;
  logic             we_s;
  logic [width-1:0] wdata_s;
  logic [width-1:0] drop_s;
  logic [width-1:0] tap_s;
  logic [width-1:0] mem_r [0:stages-1];

  // State and write pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_CLR;
      ptr_r   <= PTR_ZERO;
    end else begin
      state_r <= state_nx_s;
      ptr_r   <= ptr_nx_s;
    end
  end

  // Next state: clr overrides everything, otherwise advance on cen
  always_comb begin
    state_nx_s = state_r;
    ptr_nx_s   = ptr_r;
    if (bus.clr) begin
      state_nx_s = ST_CLR;
      ptr_nx_s   = PTR_ZERO;
    end else if (bus.cen) begin
      ptr_nx_s = (ptr_r == PTR_LAST) ? PTR_ZERO : ptr_r + PTR_ONE;
      case (state_r)
        ST_CLR: begin
          if (ptr_r == PTR_LAST) begin
            state_nx_s = ST_RUN;
          end else begin
            state_nx_s = ST_CLR;
          end
        end
        ST_RUN:  state_nx_s = ST_RUN;
        default: state_nx_s = ST_CLR;
      endcase
    end else begin
      state_nx_s = state_r;
      ptr_nx_s   = ptr_r;
    end
  end

  // State-decoded outputs and write port controls
  always_comb begin
    busy_s  = 1'b1;
    wdata_s = rstval;
    case (state_r)
      ST_CLR: begin
        busy_s  = 1'b1;
        wdata_s = rstval;
      end
      ST_RUN: begin
        busy_s  = 1'b0;
        wdata_s = bus.din;
      end
      default: begin
        busy_s  = 1'b1;
        wdata_s = rstval;
      end
    endcase
    we_s = bus.cen & ~bus.clr;
  end

  // Storage array, deliberately without reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[ptr_r] <= wdata_s;
    end
  end

  // Drop port reads the entry about to be overwritten
  always_comb begin
    if (busy_s) begin
      drop_s = rstval;
    end else begin
      drop_s = mem_r[ptr_r];
    end
  end

`ifdef JT51_SH_TAP_EN
  localparam logic [pw:0] STG = pw1'(stages);

  logic [pw:0]   dly_ext_s;
  logic [pw:0]   dly_c_s;
  logic [pw:0]   diff_s;
  logic [pw-1:0] taddr_s;

  // Tap address: (ptr - dly) mod stages, with a borrow fix-up instead of a power-of-two wrap
  always_comb begin
    dly_ext_s = pw1'(bus.tap_dly);
    if (dly_ext_s > STG) begin
      dly_c_s = STG;
    end else begin
      dly_c_s = dly_ext_s;
    end
    diff_s = {1'b0, ptr_r} - dly_c_s;
    if (diff_s[pw]) begin
      taddr_s = pw'(diff_s + STG);
    end else begin
      taddr_s = pw'(diff_s);
    end
    if (busy_s) begin
      tap_s = rstval;
    end else if (dly_c_s == {pw1{1'b0}}) begin
      tap_s = bus.din;
    end else begin
      tap_s = mem_r[taddr_s];
    end
  end
`else
  logic tap_dly_unused_s;

  assign tap_dly_unused_s = ^bus.tap_dly;
  assign tap_s            = rstval;
`endif

  assign bus.drop = drop_s;
  assign bus.tap  = tap_s;
  assign bus.busy = busy_s;

endmodule

// File: tb/tb_jt51_sh_ram.sv
// Directed bench for jt51_sh_ram: a 32-stage and a 24-stage instance share cen/din;
// din written on cen edge e is always e mod 32, so expected outputs follow from edge counts.
module tb_jt51_sh_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cen;
  logic       clr32;
  logic       clr24;
  logic [4:0] din;
  logic [5:0] tap_dly;

  int checks   = 0;
  int failures = 0;
  int e_cnt    = 0;
  int fr32     = 0;
  int fr24     = 0;

  jt51_sh_ram_if #(.width(5), .stages(32)) if32 ();
  jt51_sh_ram_if #(.width(5), .stages(24)) if24 ();

  assign if32.cen     = cen;
  assign if32.clr     = clr32;
  assign if32.din     = din;
  assign if32.tap_dly = tap_dly;
  assign if24.cen     = cen;
  assign if24.clr     = clr24;
  assign if24.din     = din;
  assign if24.tap_dly = 5'd0;

  jt51_sh_ram #(.width(5), .stages(32), .rstval(5'h1F)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if32)
  );

  jt51_sh_ram #(.width(5), .stages(24), .rstval(5'h0A)) dut24 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if24)
  );

  always #5 clk = ~clk;

  // Value visible after edge g through a delay of s ticks, given the first RUN write edge fr
  function automatic logic [4:0] exp_val(input int g, input int s, input int fr, input logic [4:0] rv);
    int src;
    src = g - s + 1;
    if (src >= fr) return 5'(src & 31);
    else return rv;
  endfunction

  task automatic tick(input logic c, input logic k32);
    cen   = c;
    clr32 = k32;
    @(posedge clk);
    #1;
    if (c) e_cnt++;
    clr32 = 1'b0;
    din   = 5'((e_cnt + 1) & 31);
  endtask

  task automatic test_reset();
    logic eb;
    rst_n = 1'b0; cen = 1'b1; clr32 = 1'b0; clr24 = 1'b0;
    din = 5'd1; tap_dly = 6'd0; e_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (if32.busy !== 1'b1) begin failures++; $display("FAIL rst_busy32 got=%0b exp=1", if32.busy); end
    checks++; if (if24.busy !== 1'b1) begin failures++; $display("FAIL rst_busy24 got=%0b exp=1", if24.busy); end
    checks++; if (if32.drop !== 5'h1F) begin failures++; $display("FAIL rst_drop32 got=%h exp=1f", if32.drop); end
    checks++; if (if24.drop !== 5'h0A) begin failures++; $display("FAIL rst_drop24 got=%h exp=0a", if24.drop); end
    checks++; if (if32.tap !== 5'h1F) begin failures++; $display("FAIL rst_tap32 got=%h exp=1f", if32.tap); end
    rst_n = 1'b1;
    for (int g = 1; g <= 33; g++) begin
      tick(1'b1, 1'b0);
      eb = (g < 32);
      checks++; if (if32.busy !== eb) begin failures++; $display("FAIL sweep_busy32 g=%0d got=%0b exp=%0b", g, if32.busy, eb); end
      eb = (g < 24);
      checks++; if (if24.busy !== eb) begin failures++; $display("FAIL sweep_busy24 g=%0d got=%0b exp=%0b", g, if24.busy, eb); end
      checks++; if (if32.drop !== 5'h1F) begin failures++; $display("FAIL sweep_drop32 g=%0d got=%h exp=1f", g, if32.drop); end
    end
    fr32 = 33;
    fr24 = 25;
  endtask

  task automatic test_drop_count();
    logic [4:0] e32, e24;
    for (int i = 0; i < 70; i++) begin
      tick(1'b1, 1'b0);
      e32 = exp_val(e_cnt, 32, fr32, 5'h1F);
      e24 = exp_val(e_cnt, 24, fr24, 5'h0A);
      checks++; if (if32.drop !== e32) begin failures++; $display("FAIL count_drop32 g=%0d got=%h exp=%h", e_cnt, if32.drop, e32); end
      checks++; if (if24.drop !== e24) begin failures++; $display("FAIL count_drop24 g=%0d got=%h exp=%h", e_cnt, if24.drop, e24); end
    end
  endtask

`ifdef JT51_SH_TAP_EN
  task automatic test_tap();
    int dl [5] = '{0, 1, 7, 32, 40};
    int dc;
    logic [4:0] et;
    for (int k = 0; k < 5; k++) begin
      tap_dly = 6'(dl[k]);
      dc = (dl[k] > 32) ? 32 : dl[k];
      for (int i = 0; i < 4; i++) begin
        if (i > 0) tick(1'b1, 1'b0);
        else #1;
        if (dc == 0) et = 5'((e_cnt + 1) & 31);
        else et = exp_val(e_cnt, dc, fr32, 5'h1F);
        checks++; if (if32.tap !== et) begin failures++; $display("FAIL tap32 dly=%0d g=%0d got=%h exp=%h", dl[k], e_cnt, if32.tap, et); end
      end
    end
  endtask
`else
  task automatic test_tap();
    int dl [6] = '{0, 1, 7, 32, 40, 63};
    for (int k = 0; k < 6; k++) begin
      tap_dly = 6'(dl[k]);
      tick(1'b1, 1'b0);
      checks++; if (if32.tap !== 5'h1F) begin failures++; $display("FAIL tap_tied32 dly=%0d got=%h exp=1f", dl[k], if32.tap); end
      checks++; if (if24.tap !== 5'h0A) begin failures++; $display("FAIL tap_tied24 dly=%0d got=%h exp=0a", dl[k], if24.tap); end
    end
  endtask
`endif

  task automatic test_cen_pattern();
    logic pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [4:0] e32, e24;
    tap_dly = 6'd7;
    for (int i = 0; i < 8; i++) begin
      tick(pat[i], 1'b0);
      e32 = exp_val(e_cnt, 32, fr32, 5'h1F);
      e24 = exp_val(e_cnt, 24, fr24, 5'h0A);
      checks++; if (if32.drop !== e32) begin failures++; $display("FAIL cen_drop32 i=%0d got=%h exp=%h", i, if32.drop, e32); end
      checks++; if (if24.drop !== e24) begin failures++; $display("FAIL cen_drop24 i=%0d got=%h exp=%h", i, if24.drop, e24); end
`ifdef JT51_SH_TAP_EN
      e32 = exp_val(e_cnt, 7, fr32, 5'h1F);
      checks++; if (if32.tap !== e32) begin failures++; $display("FAIL cen_tap32 i=%0d got=%h exp=%h", i, if32.tap, e32); end
`endif
    end
  endtask

  task automatic test_clr();
    logic eb;
    logic [4:0] e32, e24;
    tap_dly = 6'd7;
    tick(1'b0, 1'b1);
    e24 = exp_val(e_cnt, 24, fr24, 5'h0A);
    checks++; if (if32.busy !== 1'b1) begin failures++; $display("FAIL clr_busy32 got=%0b exp=1", if32.busy); end
    checks++; if (if32.drop !== 5'h1F) begin failures++; $display("FAIL clr_drop32 got=%h exp=1f", if32.drop); end
    checks++; if (if32.tap !== 5'h1F) begin failures++; $display("FAIL clr_tap32 got=%h exp=1f", if32.tap); end
    checks++; if (if24.drop !== e24) begin failures++; $display("FAIL clr_drop24 got=%h exp=%h", if24.drop, e24); end
    for (int i = 1; i <= 9; i++) begin
      tick(1'b1, 1'b0);
      checks++; if (if32.busy !== 1'b1) begin failures++; $display("FAIL clr_sweep_busy32 t=%0d got=%0b exp=1", i, if32.busy); end
    end
    tick(1'b1, 1'b1);
    checks++; if (if32.busy !== 1'b1) begin failures++; $display("FAIL reclr_busy32 got=%0b exp=1", if32.busy); end
    for (int i = 1; i <= 32; i++) begin
      tick(1'b1, 1'b0);
      eb = (i < 32);
      checks++; if (if32.busy !== eb) begin failures++; $display("FAIL reclr_sweep_busy32 t=%0d got=%0b exp=%0b", i + 10, if32.busy, eb); end
      checks++; if (if32.drop !== 5'h1F) begin failures++; $display("FAIL reclr_drop32 t=%0d got=%h exp=1f", i + 10, if32.drop); end
    end
    fr32 = e_cnt + 1;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 1'b0);
      e32 = exp_val(e_cnt, 32, fr32, 5'h1F);
      e24 = exp_val(e_cnt, 24, fr24, 5'h0A);
      checks++; if (if32.drop !== e32) begin failures++; $display("FAIL post_clr_drop32 g=%0d got=%h exp=%h", e_cnt, if32.drop, e32); end
      checks++; if (if24.drop !== e24) begin failures++; $display("FAIL post_clr_drop24 g=%0d got=%h exp=%h", e_cnt, if24.drop, e24); end
`ifdef JT51_SH_TAP_EN
      e32 = exp_val(e_cnt, 7, fr32, 5'h1F);
      checks++; if (if32.tap !== e32) begin failures++; $display("FAIL post_clr_tap32 g=%0d got=%h exp=%h", e_cnt, if32.tap, e32); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    #1;
    checks++; if (if32.busy !== 1'b1) begin failures++; $display("FAIL mid_rst_busy32 got=%0b exp=1", if32.busy); end
    checks++; if (if24.busy !== 1'b1) begin failures++; $display("FAIL mid_rst_busy24 got=%0b exp=1", if24.busy); end
    checks++; if (if32.drop !== 5'h1F) begin failures++; $display("FAIL mid_rst_drop32 got=%h exp=1f", if32.drop); end
    checks++; if (if24.drop !== 5'h0A) begin failures++; $display("FAIL mid_rst_drop24 got=%h exp=0a", if24.drop); end
    checks++; if (if32.tap !== 5'h1F) begin failures++; $display("FAIL mid_rst_tap32 got=%h exp=1f", if32.tap); end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_drop_count();
    test_tap();
    test_cen_pattern();
    test_clr();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jt51_sh_ram.md
# jt51_sh_ram

Parametrised successor to the operator/channel delay line: a `width`-bit, `stages`-deep time-multiplexed shift register built on a circular buffer so it maps to block/distributed RAM rather than flip-flops. It adds a programmable mid-line tap, a hardware clear sweep after reset or on request, and a busy flag. It sits wherever a per-slot value must reappear N enabled cycles later, such as the operator and channel pipelines clocked by the 32-slot sequencer.

## Interface
Parameters:
- `width`, 5, data bits per slot
- `stages`, 32, delay in `cen` ticks; legal range 2..256, need not be a power of two
- `rstval`, 0, value (`width` bits) written by the clear sweep and forced on outputs while clearing

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `cen`  in  1  clock enable; all state advances only when high, except `clr` capture
- `clr`  in  1  synchronous clear request; starts a sweep
- `din`  in  `width`  data inserted this tick
- `tap_dly`  in  `$clog2(stages+1)`  tap delay in ticks, 0..stages
- `drop`  out  `width`  `din` from `stages` ticks ago
- `tap`  out  `width`  `din` from `tap_dly` ticks ago
- `busy`  out  1  clear sweep in progress

## Operation
- Storage: `mem[0..stages-1]` with write pointer `ptr`, which wraps `stages-1` to 0. The memory itself has no reset.
- States: CLR and RUN.
- Async reset: `ptr`=0, state=CLR, `busy`=1.
- CLR state:
  - Each `cen` tick writes `rstval` to `mem[ptr]` and increments `ptr`. `din` is ignored.
  - When the tick writes `ptr`=`stages-1`, the next state is RUN, `ptr`=0, `busy`=0.
  - The sweep takes exactly `stages` `cen` ticks.
- RUN state: each `cen` tick writes `din` to `mem[ptr]` and increments `ptr`.
- `clr`=1 on any `clk` edge, in either state and regardless of `cen`: next state is CLR, `ptr`=0, `busy`=1. A `clr` during CLR restarts the sweep from 0. `clr` has priority over the same-cycle `cen` write.
- `drop` is a combinational read of `mem[ptr]`, i.e. the entry about to be overwritten.
- `tap` is a combinational read of `mem[(ptr - tap_dly) mod stages]`.
  - `tap_dly`=0 gives `tap`=`din` (bypass).
  - `tap_dly`=`stages` gives `tap`=`drop`.
  - `tap_dly`>`stages` is treated as `stages`.
- While `busy`=1, both `drop` and `tap` are forced to `rstval`.
- Modulo arithmetic uses the pointer width plus one bit. No power-of-two assumption is allowed.

## Timing
- Latency: `din` sampled at `cen` tick k appears on `drop` after tick k+`stages-1`, ready to be consumed at tick k+`stages`. This is identical to a flop shift register of `stages` stages.
- `tap` shows the tick k value during the interval between tick k+`tap_dly-1` and tick k+`tap_dly`.
- `busy` falls on the clock edge of the final sweep write. The first RUN write is on the next `cen` tick.
- `cen` low: `ptr`, memory, `drop` and `tap` are stable. `tap` may still change if `tap_dly` or `din` (bypass) changes.
- Reset mid-operation: state is lost and `busy` goes high asynchronously. Outputs show `rstval` at once.

## Configuration
- `JT51_SH_TAP_EN` defined: the tap read port and its modulo logic are built as described.
- `JT51_SH_TAP_EN` undefined:
  - `tap` is tied to `rstval` and `tap_dly` is ignored.
  - Only one read port remains, so the memory infers as a single-port RAM.
  - `drop`, `busy` and `clr` behaviour is unchanged.

## Test plan
- Reset release, `cen`=1, `stages`=32, `rstval`=5'h1F → `busy`=1 for exactly 32 cycles, `drop`=5'h1F throughout. After the sweep, with `din`=0, `drop`=5'h1F for 32 more ticks, then 0.
- Run with a counting `din` 0,1,2… and `stages`=32 → `drop`=n-32 at tick n. Repeat with `stages`=24 (non-power-of-two) → `drop`=n-24, with no glitch at pointer wrap.
- `tap_dly` swept over 0, 1, 7, 32 and 40 with counting `din` → `tap` = `din`, n-1, n-7, n-32 and n-32 respectively.
- `cen` pattern 1-0-0-1 with counting `din` → delay counted in `cen` ticks only, and outputs hold while `cen`=0.
- `clr` pulsed mid-stream with `cen`=0 on the same edge → `busy`=1 next cycle, outputs equal `rstval`, sweep lasts 32 `cen` ticks. A second `clr` at sweep tick 10 restarts the sweep, so it lasts 42 ticks in total.
- Build without `JT51_SH_TAP_EN` → `tap`=`rstval` for all `tap_dly`, and `drop` sequence identical to the second scenario.
